// File: rtl/monte_carlo_dir_eval_if.sv
// monte_carlo_dir_eval_if: link between the direction evaluator and its playout engine
interface monte_carlo_dir_eval_if #(
  parameter int CNT_W   = 15,
  parameter int BOARD_W = 80
);
  logic               eng_rst;
  logic [BOARD_W-1:0] eng_board;
  logic [1:0]         eng_restricted;
  logic               eng_stuck;
  logic [CNT_W-1:0]   eng_succ_count;
  modport master (output eng_rst, eng_board, eng_restricted, input eng_stuck, eng_succ_count);
  modport slave  (input eng_rst, eng_board, eng_restricted, output eng_stuck, eng_succ_count);
endinterface

// File: rtl/monte_carlo_dir_eval.sv
// monte_carlo_dir_eval: runs playouts per forced first move and reports the best direction
module monte_carlo_dir_eval #(
  parameter int CNT_W     = 15,
  parameter int ACC_W     = 32,
  parameter int TRIAL_W   = 16,
  parameter int NUM_DIR   = 4,
  parameter int BOARD_W   = 80,
  parameter int TIMEOUT_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [TRIAL_W-1:0] trials_per_dir,
  input  logic [BOARD_W-1:0] initial_board,
  input  logic [1:0]         dir_sel,
  output logic               busy,
  output logic               done,
  output logic [1:0]         best_dir,
  output logic [ACC_W-1:0]   best_total,
  output logic [ACC_W-1:0]   dir_total,
  output logic [CNT_W-1:0]   max_move_count,
  output logic [ACC_W-1:0]   total_trial_count,
  output logic [15:0]        timeout_count,
  monte_carlo_dir_eval_if.master eng
);
  typedef enum logic [2:0] {IDLE, RST_ENG, SETTLE, RUN, ACCUM, DONE} state_t;
  localparam int SW = (ACC_W > CNT_W ? ACC_W : CNT_W) + 1;
  localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});
  localparam logic [TIMEOUT_W-1:0] WD_LIM = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  state_t               state, state_n;
  logic [ACC_W-1:0]     totals [NUM_DIR];
  logic [TRIAL_W-1:0]   trials_q, trial_idx;
  logic [1:0]           dir_q;
  logic [TIMEOUT_W-1:0] wd;
  logic                 valid_q, eng_rst_q, last, wd_hit;
  logic [CNT_W-1:0]     succ_q;
  logic [BOARD_W-1:0]   board_q;
  logic [SW-1:0]        sum;
  logic [ACC_W-1:0]     new_tot;
  assign eng.eng_rst        = eng_rst_q;
  assign eng.eng_board      = board_q;
  assign eng.eng_restricted = dir_q;
  assign dir_total          = totals[dir_sel];
  // next state and the post-trial total (wide sum so the saturation check cannot wrap)
  always_comb begin
    sum     = SW'(totals[dir_q]) + SW'(succ_q);
    new_tot = !valid_q ? totals[dir_q] : (sum > ACC_MAX ? '1 : sum[ACC_W-1:0]);
    last    = trial_idx == trials_q - 1'b1;
    wd_hit  = wd == WD_LIM;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (trials_per_dir == '0 ? DONE : RST_ENG) : IDLE;
      RST_ENG: state_n = SETTLE;
      SETTLE:  state_n = RUN;
      RUN:     state_n = (eng.eng_stuck || wd_hit) ? ACCUM : RUN;
      ACCUM:   state_n = (last && dir_q == 2'(NUM_DIR - 1)) ? DONE : RST_ENG;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  // state register with status outputs registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      eng_rst_q <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= state_n inside {RST_ENG, SETTLE, RUN, ACCUM};
      done      <= state_n == DONE;
      eng_rst_q <= state_n == RST_ENG;
    end
  end
  // run bookkeeping, watchdog and statistics accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIR; i++) totals[i] <= '0;
      board_q           <= '0;
      trials_q          <= '0;
      trial_idx         <= '0;
      dir_q             <= '0;
      wd                <= '0;
      valid_q           <= 1'b0;
      succ_q            <= '0;
      best_dir          <= '0;
      best_total        <= '0;
      max_move_count    <= '0;
      total_trial_count <= '0;
      timeout_count     <= '0;
    end else if (state == IDLE && start) begin
      for (int i = 0; i < NUM_DIR; i++) totals[i] <= '0;
      board_q           <= initial_board;
      trials_q          <= trials_per_dir;
      trial_idx         <= '0;
      dir_q             <= '0;
      best_dir          <= '0;
      best_total        <= '0;
      max_move_count    <= '0;
      total_trial_count <= '0;
      timeout_count     <= '0;
    end else if (state == SETTLE) begin
      wd <= '0;
    end else if (state == RUN) begin
      wd      <= wd + 1'b1;
      valid_q <= eng.eng_stuck;
      succ_q  <= eng.eng_succ_count;
    end else if (state == ACCUM && !abort) begin
      totals[dir_q] <= new_tot;
      if (valid_q && succ_q > max_move_count) max_move_count <= succ_q;
      if (!valid_q && timeout_count != '1) timeout_count <= timeout_count + 1'b1;
      if (total_trial_count != '1) total_trial_count <= total_trial_count + 1'b1;
      if (last) begin
        if (dir_q == '0 || new_tot > best_total) begin
          best_total <= new_tot;
          best_dir   <= dir_q;
        end
        trial_idx <= '0;
        dir_q     <= dir_q + 1'b1;
      end else begin
        trial_idx <= trial_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_monte_carlo_dir_eval.sv
// tb_monte_carlo_dir_eval: directed vectors against two evaluator configurations
module tb_monte_carlo_dir_eval;
  localparam logic [79:0] BOARD0 = 80'h0123_4567_89ab_cdef_1357;
  logic        clk = 0, rst = 1, start_a = 0, start_b = 0, abort = 0;
  logic [15:0] trials = 0;
  logic [79:0] board = BOARD0;
  logic [1:0]  dir_sel = 0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [1:0]  best_dir_a, best_dir_b;
  logic [31:0] best_total_a, dir_total_a, ttc_a;
  logic [3:0]  best_total_b, dir_total_b, ttc_b;
  logic [14:0] max_a, max_b;
  logic [15:0] toc_a, toc_b;
  monte_carlo_dir_eval_if #(.CNT_W(15), .BOARD_W(80)) ea ();
  monte_carlo_dir_eval_if #(.CNT_W(15), .BOARD_W(80)) eb ();
  monte_carlo_dir_eval #(.TIMEOUT_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .trials_per_dir(trials),
    .initial_board(board), .dir_sel(dir_sel), .busy(busy_a), .done(done_a),
    .best_dir(best_dir_a), .best_total(best_total_a), .dir_total(dir_total_a),
    .max_move_count(max_a), .total_trial_count(ttc_a), .timeout_count(toc_a), .eng(ea.master));
  monte_carlo_dir_eval #(.ACC_W(4), .TIMEOUT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .trials_per_dir(trials),
    .initial_board(board), .dir_sel(dir_sel), .busy(busy_b), .done(done_b),
    .best_dir(best_dir_b), .best_total(best_total_b), .dir_total(dir_total_b),
    .max_move_count(max_b), .total_trial_count(ttc_b), .timeout_count(toc_b), .eng(eb.master));
  always #5 clk = ~clk;
  int seq [12];
  int delay_a = 10, cnt_a = 0, k_a = 0, cnt_b = 0;
  int busy_n = 0, done_n = 0, erst_n = 0, done_nb = 0, busy_nb = 0;
  int pass_n = 0, total_n = 0;
  // engine models: game over after a fixed number of cycles out of reset
  always @(posedge clk) begin
    cnt_a <= ea.eng_rst ? 0 : cnt_a + 1;
    cnt_b <= eb.eng_rst ? 0 : cnt_b + 1;
    if (start_a && !busy_a) k_a <= 0;
    else if (ea.eng_rst) k_a <= k_a + 1;
  end
  assign ea.eng_stuck      = !ea.eng_rst && cnt_a >= delay_a;
  assign ea.eng_succ_count = (k_a >= 1 && k_a <= 12) ? 15'(seq[k_a-1]) : 15'd0;
  assign eb.eng_stuck      = !eb.eng_rst && cnt_b >= 15;
  assign eb.eng_succ_count = 15'd10;
  // activity counters since the last accepted start
  always @(posedge clk) begin
    if (start_a && !busy_a) begin
      busy_n <= 0; done_n <= 0; erst_n <= 0;
    end else begin
      busy_n <= busy_n + int'(busy_a); done_n <= done_n + int'(done_a); erst_n <= erst_n + int'(ea.eng_rst);
    end
    if (start_b && !busy_b) begin
      busy_nb <= 0; done_nb <= 0;
    end else begin
      busy_nb <= busy_nb + int'(busy_b); done_nb <= done_nb + int'(done_b);
    end
  end
  task automatic chk(input string name, input longint act, input longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic go_a(input int t);
    @(negedge clk); trials = 16'(t); start_a = 1;
    @(negedge clk); start_a = 0;
  endtask
  task automatic wait_done_a(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_a) begin ok = 1; break; end
    end
  endtask
  task automatic wait_ttc_a(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ttc_a == 32'(n)) begin ok = 1; break; end
    end
  endtask
  typedef struct {
    int trials; int delay; int succ[12];
    int bdir; int btot; int mx; int ttc; int toc; int tot[4]; int busy;
  } vec_t;
  vec_t vt [4];
  bit ok;
  initial begin
    vt[0] = '{1, 10, '{5,9,9,2,0,0,0,0,0,0,0,0}, 1, 9, 9, 4, 0, '{5,9,9,2}, 52};
    vt[1] = '{3, 10, '{6,6,6,6,6,6,4,7,20,6,6,6}, 2, 31, 20, 12, 0, '{18,18,31,18}, 156};
    vt[2] = '{1, 100, '{7,7,7,7,0,0,0,0,0,0,0,0}, 0, 0, 0, 4, 4, '{0,0,0,0}, 72};
    vt[3] = '{2, 1, '{1,2,3,4,5,6,7,8,0,0,0,0}, 3, 15, 8, 8, 0, '{3,7,11,15}, 32};
    #1 rst = 0;
    #1;
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_eng_rst", ea.eng_rst, 0);
    chk("reset_best_total", best_total_a, 0);
    chk("reset_ttc", ttc_a, 0);
    @(negedge clk) rst = 1;
    for (int i = 0; i < 4; i++) begin
      seq = vt[i].succ;
      delay_a = vt[i].delay;
      go_a(vt[i].trials);
      if (i == 0) board = ~BOARD0;
      wait_done_a(ok);
      chk($sformatf("v%0d_done_seen", i), ok, 1);
      @(negedge clk);
      if (i == 0) chk("eng_board_latched", ea.eng_board == BOARD0, 1);
      chk($sformatf("v%0d_best_dir", i), best_dir_a, vt[i].bdir);
      chk($sformatf("v%0d_best_total", i), best_total_a, vt[i].btot);
      chk($sformatf("v%0d_max", i), max_a, vt[i].mx);
      chk($sformatf("v%0d_ttc", i), ttc_a, vt[i].ttc);
      chk($sformatf("v%0d_toc", i), toc_a, vt[i].toc);
      for (int d = 0; d < 4; d++) begin
        dir_sel = 2'(d); #1;
        chk($sformatf("v%0d_dir_total%0d", i, d), dir_total_a, vt[i].tot[d]);
      end
      chk($sformatf("v%0d_busy_cycles", i), busy_n, vt[i].busy);
      chk($sformatf("v%0d_done_pulses", i), done_n, 1);
      chk($sformatf("v%0d_eng_rst_cycles", i), erst_n, vt[i].trials * 4);
    end
    go_a(0);
    chk("t0_done_next", done_a, 1);
    chk("t0_busy", busy_a, 0);
    chk("t0_best_dir", best_dir_a, 0);
    chk("t0_best_total", best_total_a, 0);
    chk("t0_ttc", ttc_a, 0);
    chk("t0_max", max_a, 0);
    dir_sel = 3; #1;
    chk("t0_dir_total3", dir_total_a, 0);
    @(negedge clk);
    chk("t0_done_low", done_a, 0);
    chk("t0_busy_cycles", busy_n, 0);
    @(negedge clk); trials = 2; start_b = 1;
    @(negedge clk); start_b = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_b) begin ok = 1; break; end
    end
    chk("sat_done_seen", ok, 1);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      dir_sel = 2'(d); #1;
      chk($sformatf("sat_dir_total%0d", d), dir_total_b, 15);
    end
    chk("sat_best_dir", best_dir_b, 0);
    chk("sat_best_total", best_total_b, 15);
    chk("sat_toc", toc_b, 0);
    chk("sat_ttc", ttc_b, 8);
    chk("sat_max", max_b, 10);
    chk("sat_busy_cycles", busy_nb, 144);
    chk("sat_done_pulses", done_nb, 1);
    seq = '{5,5,5,5,5,5,5,5,5,5,5,5};
    delay_a = 10;
    go_a(1);
    wait_ttc_a(2, ok);
    chk("rst_reach_trial2", ok, 1);
    chk("rst_restricted", ea.eng_restricted, 2);
    repeat (5) @(negedge clk);
    chk("rst_busy_before", busy_a, 1);
    #2 rst = 0;
    #1;
    chk("rst_busy_now", busy_a, 0);
    chk("rst_eng_rst_now", ea.eng_rst, 0);
    chk("rst_ttc_now", ttc_a, 0);
    chk("rst_best_total_now", best_total_a, 0);
    chk("rst_max_now", max_a, 0);
    @(negedge clk) rst = 1;
    go_a(1);
    wait_ttc_a(2, ok);
    chk("ign_reach_trial2", ok, 1);
    start_a = 1;
    @(negedge clk) start_a = 0;
    chk("ign_ttc_kept", ttc_a, 2);
    chk("ign_busy", busy_a, 1);
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk) abort = 0;
    chk("abort_busy", busy_a, 0);
    chk("abort_eng_rst", ea.eng_rst, 0);
    chk("abort_ttc_kept", ttc_a, 2);
    dir_sel = 1; #1;
    chk("abort_dir_total1", dir_total_a, 5);
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_n, 0);
    chk("abort_stays_idle", busy_a, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/monte_carlo_dir_eval.md
Name: monte_carlo_dir_eval

Overview:
- Parametrised successor to the single-run Monte Carlo statistics collector.
- Runs `trials_per_dir` random playouts for each of NUM_DIR forced first-move directions on one `logic2048` engine instance.
- Accumulates per-direction move totals, a global maximum and a trial count, flags stuck or hung engines via a watchdog, and reports the best direction with a done pulse.
- Sits between the top-level move selector and the playout engine.

Parameters:
- CNT_W, 15: width of the engine `succ_count` and of `max_move_count`.
- ACC_W, 32: width of the per-direction totals, `best_total` and `total_trial_count`.
- TRIAL_W, 16: width of `trials_per_dir`.
- NUM_DIR, 4: number of directions evaluated. Fixed at 4 in this generation; `dir` fields are 2 bits wide.
- BOARD_W, 80: board vector width.
- TIMEOUT_W, 20: watchdog counter width. The limit is 2^TIMEOUT_W-1 cycles in RUN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin evaluation; sampled only in IDLE
- abort  in  1  synchronous abandon of a running evaluation
- trials_per_dir  in  TRIAL_W  playouts per direction; latched on accepted start
- initial_board  in  BOARD_W  board; latched on accepted start
- dir_sel  in  2  selects the per-direction total shown on dir_total
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse when results are valid
- best_dir  out  2  direction with the highest total
- best_total  out  ACC_W  total of best_dir
- dir_total  out  ACC_W  total of direction dir_sel; combinational read of registers
- max_move_count  out  CNT_W  largest succ_count over all completed trials
- total_trial_count  out  ACC_W  trials finished, including timed-out trials
- timeout_count  out  16  trials aborted by the watchdog; saturating
- eng_rst  out  1  engine reset; registered, high exactly while state is RST_ENG
- eng_board  out  BOARD_W  latched board
- eng_restricted  out  2  current forced direction
- eng_stuck  in  1  engine has reached game over
- eng_succ_count  in  CNT_W  move count of the finished playout

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - All outputs and registers go to 0, including eng_rst=0, busy=0 and done=0.
- States: IDLE, RST_ENG, SETTLE, RUN, ACCUM, DONE.
- IDLE:
  - start=1 latches board and trials_per_dir.
  - Clears the four totals, best_total, best_dir, max_move_count, total_trial_count, timeout_count, the direction index and the trial index.
  - Goes to RST_ENG, or to DONE if trials_per_dir==0.
  - start in any other state is ignored.
- RST_ENG: 1 cycle, eng_rst=1, then SETTLE.
- SETTLE: 1 cycle, eng_stuck ignored, watchdog cleared, then RUN.
- RUN:
  - The watchdog increments each cycle.
  - eng_stuck=1 goes to ACCUM with valid=1.
  - Watchdog reaching its limit without stuck goes to ACCUM with valid=0.
  - If stuck and the limit occur in the same cycle, stuck wins (valid=1).
- ACCUM (1 cycle):
  - If valid=1: totals[dir] += eng_succ_count, saturating at all-ones. max_move_count updates if eng_succ_count > max_move_count.
  - If valid=0: timeout_count += 1, saturating; totals are not changed.
  - total_trial_count += 1 in both cases, saturating.
  - If this was the last trial of the direction:
    - Compare the final totals[dir] against best_total using strict greater-than. Ties keep the lower index. Direction 0 always initialises the best.
    - If dir==NUM_DIR-1, go to DONE. Otherwise increment dir, clear the trial index, and go to RST_ENG.
  - Otherwise increment the trial index and go to RST_ENG.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Result retention: results hold until the next accepted start.
- Per-trial latency: 2 + R + 1 cycles, where R is the number of RUN cycles including the stuck-detect cycle.
- abort=1 in any non-IDLE state:
  - Next state is IDLE with eng_rst=0 and busy=0.
  - No done pulse is issued.
  - Partial results remain readable.
- abort has priority over all other transitions. abort in IDLE has no effect.
- trials_per_dir==0: done is asserted in the cycle after start is sampled. best_dir=0 and all statistics are 0.
- Width rules:
  - succ_count is zero-extended to ACC_W before adding.
  - All counters saturate rather than wrap.

Test Plan:
- trials=1, engine model asserts stuck 10 cycles after SETTLE with succ 5/9/9/2 for dir 0..3 -> best_dir=1, best_total=9, max_move_count=9, total_trial_count=4, exactly one done pulse; eng_rst high one cycle per trial.
- trials=3, dir2 succ 4,7,20 and all other dirs succ 6 each -> dir_total(dir_sel=2)=31, best_dir=2, max_move_count=20, total_trial_count=12.
- trials=0 with start held for 1 cycle -> done on the next cycle, busy never rises, all outputs 0.
- TIMEOUT_W=4, engine never stuck, trials=1 -> each trial takes 15 RUN cycles; timeout_count=4, total_trial_count=4, best_dir=0, best_total=0.
- ACC_W=4, trials=2, succ=10 each -> dir totals saturate at 15; stuck coinciding with the watchdog limit counts as a valid trial.
- Assert rst=0 mid-RUN -> busy, eng_rst and all stats are 0 immediately. After release, start while busy is ignored and abort mid-run returns to IDLE with no done pulse.
